// File: rtl/amstrad_memarb_pkg.sv
// Shared definitions for the Amstrad memory arbiter.
// Holds the arbiter FSM state enum, the SDRAM byte-enable constants and the
// address widths used by the motherboard and SDRAM sides.
// Build option AMSTRAD_MEMARB_VID_PREFETCH_EN adds the PREF state used by the
// video prefetch buffer.
package amstrad_memarb_pkg;

    localparam int CPU_AW = 23;   // CPU byte address width
    localparam int SD_AW  = 22;   // SDRAM word address width
    localparam int VID_AW = 15;   // video word address width

    localparam logic [1:0] BE_LO = 2'b01;
    localparam logic [1:0] BE_HI = 2'b10;
    localparam logic [1:0] BE_W  = 2'b11;

`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
    typedef enum logic [1:0] {IDLE, VID, CPU, PREF} arb_state_t;
`else
    typedef enum logic [1:0] {IDLE, VID, CPU} arb_state_t;
`endif

    // Byte lane selected by a CPU byte address: odd bytes live in the high half.
    function automatic logic [1:0] cpu_be(input logic addr_lsb);
        return addr_lsb ? BE_HI : BE_LO;
    endfunction

endpackage

// File: rtl/amstrad_vid_prefetch.sv
// One-entry video prefetch buffer (only built with AMSTRAD_MEMARB_VID_PREFETCH_EN).
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   fill              load fill_addr/fill_data into the buffer
//   fill_addr/data    video word address and data of a completed prefetch
//   inval             a CPU write is being issued to SDRAM word inval_word
//   inval_word        SDRAM word address of that write
//   lookup_addr       video word address to compare against the buffer
//   hit, hit_data     buffer holds lookup_addr; its data
module amstrad_vid_prefetch
    import amstrad_memarb_pkg::*;
#(
    parameter logic [SD_AW-1:0] VID_BASE = 22'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fill,
    input  logic [VID_AW-1:0] fill_addr,
    input  logic [15:0]       fill_data,
    input  logic              inval,
    input  logic [SD_AW-1:0]  inval_word,
    input  logic [VID_AW-1:0] lookup_addr,
    output logic              hit,
    output logic [15:0]       hit_data
);

    logic              buf_valid_reg;
    logic [VID_AW-1:0] buf_addr_reg;
    logic [15:0]       buf_data_reg;
    logic              fill_clobbered;
    logic              buf_clobbered;

    always_comb begin
        // A write issued in the same cycle as the fill lands after the
        // prefetch read, so the filled word is already stale.
        fill_clobbered = inval && (inval_word == VID_BASE + {{(SD_AW-VID_AW){1'b0}}, fill_addr});
        buf_clobbered  = inval && (inval_word == VID_BASE + {{(SD_AW-VID_AW){1'b0}}, buf_addr_reg});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_valid_reg <= 1'b0;
            buf_addr_reg  <= '0;
            buf_data_reg  <= '0;
        end else if (fill) begin
            buf_valid_reg <= !fill_clobbered;
            buf_addr_reg  <= fill_addr;
            buf_data_reg  <= fill_data;
        end else if (buf_clobbered) begin
            buf_valid_reg <= 1'b0;
        end
    end

    assign hit      = buf_valid_reg && (lookup_addr == buf_addr_reg);
    assign hit_data = buf_data_reg;

endmodule

// File: rtl/amstrad_mem_arbiter.sv
// Two-client arbiter: gate-array video word fetches and CPU byte accesses
// share one SDRAM request/acknowledge port. Video has fixed priority.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   vram_req/vram_addr       video fetch strobe and word address
//   vram_din/vram_valid      fetched word, one-cycle update pulse
//   mem_addr/mem_dout        CPU byte address and write data
//   mem_rd/mem_wr            CPU access levels (rising edge starts an access)
//   mem_din/cpu_done         CPU read byte (held), completion pulse
//   sd_req/sd_we/sd_addr/sd_be/sd_dout/sd_din/sd_ack   SDRAM port
//   vid_overrun              sticky: a video request overwrote a pending one
// Build option AMSTRAD_MEMARB_VID_PREFETCH_EN enables the next-word video
// prefetch buffer (amstrad_vid_prefetch).
module amstrad_mem_arbiter
    import amstrad_memarb_pkg::*;
#(
    parameter logic [SD_AW-1:0] VID_BASE = 22'h000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              vram_req,
    input  logic [VID_AW-1:0] vram_addr,
    output logic [15:0]       vram_din,
    output logic              vram_valid,
    input  logic [CPU_AW-1:0] mem_addr,
    input  logic [7:0]        mem_dout,
    input  logic              mem_rd,
    input  logic              mem_wr,
    output logic [7:0]        mem_din,
    output logic              cpu_done,
    output logic              sd_req,
    output logic              sd_we,
    output logic [SD_AW-1:0]  sd_addr,
    output logic [1:0]        sd_be,
    output logic [15:0]       sd_dout,
    input  logic [15:0]       sd_din,
    input  logic              sd_ack,
    output logic              vid_overrun
);

    arb_state_t state_reg, state_next;

    logic              vid_pend_reg;
    logic [VID_AW-1:0] vid_addr_reg;
    logic              vid_overrun_reg;
    logic              cpu_pend_reg;
    logic [CPU_AW-1:0] cpu_addr_reg;
    logic [7:0]        cpu_data_reg;
    logic              cpu_we_reg;
    logic              rw_prev_reg;

    logic              sd_req_reg;
    logic              sd_we_reg;
    logic [SD_AW-1:0]  sd_addr_reg;
    logic [1:0]        sd_be_reg;
    logic [15:0]       sd_dout_reg;
    logic [15:0]       vram_din_reg;
    logic              vram_valid_reg;
    logic [7:0]        mem_din_reg;
    logic              cpu_done_reg;

    logic rw_level, cpu_edge;
    logic vid_done, cpu_xfer_done, slot_free;
    logic issue_vid, issue_cpu, issue_pref;
    logic vid_hit, vid_capture, overrun_set;

`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
    logic              pref_pend_reg;
    logic [VID_AW-1:0] pref_addr_reg;
    logic [VID_AW-1:0] cur_vid_addr_reg;
    logic              pref_done;
    logic              buf_hit;
    logic [15:0]       buf_data;

    amstrad_vid_prefetch #(
        .VID_BASE(VID_BASE)
    ) u_prefetch (
        .clk        (clk),
        .reset      (reset),
        .fill       (pref_done),
        .fill_addr  (pref_addr_reg),
        .fill_data  (sd_din),
        .inval      (issue_cpu && cpu_we_reg),
        .inval_word (cpu_addr_reg[CPU_AW-1:1]),
        .lookup_addr(vram_addr),
        .hit        (buf_hit),
        .hit_data   (buf_data)
    );
`endif

    always_comb begin
        state_next    = state_reg;
        rw_level      = mem_rd | mem_wr;
        cpu_edge      = rw_level && !rw_prev_reg;
        vid_done      = (state_reg == VID) && sd_ack;
        cpu_xfer_done = (state_reg == CPU) && sd_ack;
        // The port is free in IDLE, or in the ack cycle of any access, so the
        // next request goes out the cycle after an ack (ack in IDLE is a no-op).
        slot_free     = (state_reg == IDLE) || sd_ack;
        issue_vid     = slot_free && vid_pend_reg;
        issue_cpu     = slot_free && !vid_pend_reg && cpu_pend_reg;
        issue_pref    = 1'b0;
        vid_hit       = 1'b0;
`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
        pref_done     = (state_reg == PREF) && sd_ack;
        issue_pref    = slot_free && !vid_pend_reg && !cpu_pend_reg && pref_pend_reg;
        // A hit colliding with a VID completion would fight over vram_din;
        // let it take the normal SDRAM path instead.
        vid_hit       = vram_req && buf_hit && !vid_done;
`endif
        vid_capture   = vram_req && !vid_hit;
        // A request landing on the ack of the current fetch is a fresh one.
        overrun_set   = vid_capture && (vid_pend_reg || ((state_reg == VID) && !sd_ack));

        if (issue_vid) begin
            state_next = VID;
        end else if (issue_cpu) begin
            state_next = CPU;
`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
        end else if (issue_pref) begin
            state_next = PREF;
`endif
        end else if (sd_ack) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vid_pend_reg    <= 1'b0;
            vid_addr_reg    <= '0;
            vid_overrun_reg <= 1'b0;
            cpu_pend_reg    <= 1'b0;
            cpu_addr_reg    <= '0;
            cpu_data_reg    <= '0;
            cpu_we_reg      <= 1'b0;
            rw_prev_reg     <= 1'b0;
            sd_req_reg      <= 1'b0;
            sd_we_reg       <= 1'b0;
            sd_addr_reg     <= '0;
            sd_be_reg       <= '0;
            sd_dout_reg     <= '0;
            vram_din_reg    <= 16'hFFFF;
            vram_valid_reg  <= 1'b0;
            mem_din_reg     <= 8'hFF;
            cpu_done_reg    <= 1'b0;
`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
            pref_pend_reg    <= 1'b0;
            pref_addr_reg    <= '0;
            cur_vid_addr_reg <= '0;
`endif
        end else begin
            rw_prev_reg <= rw_level;

            // A capture in the issue cycle re-arms the flag with the new address.
            if (vid_capture) begin
                vid_pend_reg <= 1'b1;
                vid_addr_reg <= vram_addr;
            end else if (issue_vid) begin
                vid_pend_reg <= 1'b0;
            end
            if (overrun_set) begin
                vid_overrun_reg <= 1'b1;
            end

            if (cpu_edge) begin
                cpu_pend_reg <= 1'b1;
                cpu_addr_reg <= mem_addr;
                cpu_data_reg <= mem_dout;
                cpu_we_reg   <= mem_wr;
            end else if (issue_cpu) begin
                cpu_pend_reg <= 1'b0;
            end

            // Command fields only change on issue, so they hold until the ack.
            sd_req_reg <= issue_vid || issue_cpu || issue_pref;
            if (issue_vid) begin
                sd_we_reg   <= 1'b0;
                sd_be_reg   <= BE_W;
                sd_addr_reg <= VID_BASE + {{(SD_AW-VID_AW){1'b0}}, vid_addr_reg};
            end else if (issue_cpu) begin
                sd_we_reg   <= cpu_we_reg;
                sd_be_reg   <= cpu_be(cpu_addr_reg[0]);
                sd_addr_reg <= cpu_addr_reg[CPU_AW-1:1];
                sd_dout_reg <= {cpu_data_reg, cpu_data_reg};
`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
            end else if (issue_pref) begin
                sd_we_reg   <= 1'b0;
                sd_be_reg   <= BE_W;
                sd_addr_reg <= VID_BASE + {{(SD_AW-VID_AW){1'b0}}, pref_addr_reg};
`endif
            end

            vram_valid_reg <= vid_done || vid_hit;
            if (vid_done) begin
                vram_din_reg <= sd_din;
`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
            end else if (vid_hit) begin
                vram_din_reg <= buf_data;
`endif
            end

            // sd_be_reg still names the byte lane of the access being acked.
            cpu_done_reg <= cpu_xfer_done;
            if (cpu_xfer_done && !sd_we_reg) begin
                mem_din_reg <= sd_be_reg[1] ? sd_din[15:8] : sd_din[7:0];
            end

`ifdef AMSTRAD_MEMARB_VID_PREFETCH_EN
            if (issue_vid) begin
                cur_vid_addr_reg <= vid_addr_reg;
            end
            if (vid_done) begin
                pref_pend_reg <= 1'b1;
                pref_addr_reg <= cur_vid_addr_reg + 1'b1;
            end else if (issue_pref) begin
                pref_pend_reg <= 1'b0;
            end
`endif
        end
    end

    assign sd_req      = sd_req_reg;
    assign sd_we       = sd_we_reg;
    assign sd_addr     = sd_addr_reg;
    assign sd_be       = sd_be_reg;
    assign sd_dout     = sd_dout_reg;
    assign vram_din    = vram_din_reg;
    assign vram_valid  = vram_valid_reg;
    assign mem_din     = mem_din_reg;
    assign cpu_done    = cpu_done_reg;
    assign vid_overrun = vid_overrun_reg;

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
// Scoreboard bench for amstrad_mem_arbiter (default build).
// Stimulus pushes expected SDRAM commands and expected read results into
// queues; an SDRAM responder and an output monitor pop and compare.
module tb_amstrad_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        vram_req = 1'b0;
    logic [14:0] vram_addr = '0;
    logic [15:0] vram_din;
    logic        vram_valid;
    logic [22:0] mem_addr = '0;
    logic [7:0]  mem_dout = '0;
    logic        mem_rd = 1'b0;
    logic        mem_wr = 1'b0;
    logic [7:0]  mem_din;
    logic        cpu_done;
    logic        sd_req;
    logic        sd_we;
    logic [21:0] sd_addr;
    logic [1:0]  sd_be;
    logic [15:0] sd_dout;
    logic [15:0] sd_din = '0;
    logic        sd_ack = 1'b0;
    logic        vid_overrun;

    amstrad_mem_arbiter #(.VID_BASE(22'h000000)) dut (
        .clk(clk), .reset(reset),
        .vram_req(vram_req), .vram_addr(vram_addr), .vram_din(vram_din), .vram_valid(vram_valid),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_din(mem_din), .cpu_done(cpu_done),
        .sd_req(sd_req), .sd_we(sd_we), .sd_addr(sd_addr), .sd_be(sd_be), .sd_dout(sd_dout),
        .sd_din(sd_din), .sd_ack(sd_ack), .vid_overrun(vid_overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [21:0] addr;
        logic        we;
        logic [1:0]  be;
        logic [15:0] dout;
    } sd_cmd_t;

    sd_cmd_t     sd_q[$];
    logic [15:0] vid_q[$];
    logic [7:0]  cpu_q[$];

    // Reference memory (model) and the SDRAM contents seen by the responder.
    logic [15:0] ref_mem   [0:32767];
    logic [15:0] sdram_mem [0:32767];

    int   n_vec = 0;
    int   n_miss = 0;
    int   force_lat = 0;
    bit   skip_stab = 1'b0;
    bit   resp_busy = 1'b0;
    int   n_req = 0;
    int   n_vvalid = 0;
    int   last_req_cyc = 0;
    int   last_ack_cyc = -100;
    int   last_gap = 0;
    logic [7:0] exp_mem_din = 8'hFF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- model: expected SDRAM command and results -------------
    task automatic exp_vid(input logic [14:0] a);
        sd_cmd_t e;
        e.addr = {7'd0, a};
        e.we   = 1'b0;
        e.be   = 2'b11;
        e.dout = '0;
        sd_q.push_back(e);
        vid_q.push_back(ref_mem[a]);
    endtask

    task automatic exp_cpu(input logic [22:0] a, input logic we, input logic [7:0] d);
        sd_cmd_t e;
        logic [14:0] w;
        w      = a[15:1];
        e.addr = a[22:1];
        e.we   = we;
        e.be   = a[0] ? 2'b10 : 2'b01;
        e.dout = {d, d};
        sd_q.push_back(e);
        if (we) begin
            if (a[0]) ref_mem[w][15:8] = d;
            else      ref_mem[w][7:0]  = d;
        end else begin
            exp_mem_din = a[0] ? ref_mem[w][15:8] : ref_mem[w][7:0];
        end
        cpu_q.push_back(exp_mem_din);
    endtask

    // ---------------- drivers ----------------
    task automatic vid_strobe(input logic [14:0] a);
        vram_addr = a;
        vram_req  = 1'b1;
        tick();
        vram_req  = 1'b0;
    endtask

    task automatic cpu_start(input logic [22:0] a, input logic we, input logic [7:0] d);
        mem_addr = a;
        mem_dout = d;
        if (we) mem_wr = 1'b1;
        else    mem_rd = 1'b1;
    endtask

    task automatic cpu_stop();
        mem_rd = 1'b0;
        mem_wr = 1'b0;
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while ((sd_q.size() != 0 || vid_q.size() != 0 || cpu_q.size() != 0 || resp_busy) && t < 300) begin
            tick();
            t++;
        end
        chk({name, "_timeout"}, 32'(t >= 300), 0);
        tick();
    endtask

    // ---------------- SDRAM responder ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (sd_req === 1'b1) begin
                sd_cmd_t got;
                sd_cmd_t e;
                int lat;
                bit bad;
                resp_busy    = 1'b1;
                n_req++;
                last_gap     = cyc - last_ack_cyc;
                last_req_cyc = cyc;
                got.addr = sd_addr;
                got.we   = sd_we;
                got.be   = sd_be;
                got.dout = sd_dout;
                if (sd_q.size() == 0) begin
                    chk("sd_unexpected_req", 1, 0);
                end else begin
                    e = sd_q.pop_front();
                    chk("sd_addr", 32'(got.addr), 32'(e.addr));
                    chk("sd_we", 32'(got.we), 32'(e.we));
                    chk("sd_be", 32'(got.be), 32'(e.be));
                    if (e.we) chk("sd_dout", 32'(got.dout), 32'(e.dout));
                end
                lat = (force_lat > 0) ? force_lat : int'($urandom_range(1, 4));
                bad = 1'b0;
                repeat (lat) begin
                    @(negedge clk);
                    if (!skip_stab && (sd_req !== 1'b0 || sd_addr !== got.addr || sd_we !== got.we ||
                                       sd_be !== got.be || sd_dout !== got.dout)) bad = 1'b1;
                end
                chk("sd_hold_stable", 32'(bad), 0);
                @(posedge clk);
                #1;
                sd_ack = 1'b1;
                sd_din = sdram_mem[got.addr[14:0]];
                if (got.we) begin
                    if (got.be[0]) sdram_mem[got.addr[14:0]][7:0]  = got.dout[7:0];
                    if (got.be[1]) sdram_mem[got.addr[14:0]][15:8] = got.dout[15:8];
                end
                last_ack_cyc = cyc;
                @(posedge clk);
                #1;
                sd_ack    = 1'b0;
                sd_din    = 16'($urandom);
                resp_busy = 1'b0;
            end
        end
    end

    // ---------------- output monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (vram_valid === 1'b1) begin
                n_vvalid++;
                chk("vid_latency", cyc, last_ack_cyc + 1);
                if (vid_q.size() == 0) chk("vid_unexpected", 1, 0);
                else                   chk("vram_din", 32'(vram_din), 32'(vid_q.pop_front()));
            end
            if (cpu_done === 1'b1) begin
                chk("cpu_latency", cyc, last_ack_cyc + 1);
                if (cpu_q.size() == 0) chk("cpu_unexpected", 1, 0);
                else                   chk("mem_din", 32'(mem_din), 32'(cpu_q.pop_front()));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int c0, n0, t;
        logic [14:0] va, va2;
        logic [22:0] ca;
        logic [7:0]  d;
        int op, hold;

        for (int i = 0; i < 32768; i++) begin
            ref_mem[i]   = 16'(i * 40503) ^ 16'h5A3C;
            sdram_mem[i] = 16'(i * 40503) ^ 16'h5A3C;
        end
        ref_mem[15'h1234]   = 16'hBEEF;
        sdram_mem[15'h1234] = 16'hBEEF;

        // Reset state
        repeat (4) tick();
        chk("rst_sd_req", 32'(sd_req), 0);
        chk("rst_sd_we", 32'(sd_we), 0);
        chk("rst_vram_valid", 32'(vram_valid), 0);
        chk("rst_cpu_done", 32'(cpu_done), 0);
        chk("rst_overrun", 32'(vid_overrun), 0);
        chk("rst_vram_din", 32'(vram_din), 32'hFFFF);
        chk("rst_mem_din", 32'(mem_din), 32'hFF);
        chk("rst_sd_be", 32'(sd_be), 0);
        chk("rst_sd_addr", 32'(sd_addr), 0);
        reset = 1'b0;
        tick();

        // Single video fetch, ack three cycles after the request
        force_lat = 2;
        n0 = n_vvalid;
        c0 = cyc;
        exp_vid(15'h1234);
        vid_strobe(15'h1234);
        drain("vid_single");
        chk("vid_req_timing", last_req_cyc - c0, 2);
        chk("vid_valid_count", n_vvalid - n0, 1);
        force_lat = 0;

        // CPU byte write to an odd address
        exp_cpu(23'h004001, 1'b1, 8'h5A);
        cpu_start(23'h004001, 1'b1, 8'h5A);
        repeat (3) tick();
        cpu_stop();
        drain("cpu_write");

        // Read held for 10 cycles issues one request; reads back the byte
        n0 = n_req;
        exp_cpu(23'h004001, 1'b0, 8'h00);
        cpu_start(23'h004001, 1'b0, 8'h00);
        repeat (10) tick();
        cpu_stop();
        drain("cpu_read_held");
        chk("rd_held_one_req", n_req - n0, 1);

        // Collision: video first, CPU right after the video ack
        va = 15'h0321;
        ca = 23'h000A42;
        exp_vid(va);
        exp_cpu(ca, 1'b0, 8'h00);
        vram_addr = va;
        vram_req  = 1'b1;
        cpu_start(ca, 1'b0, 8'h00);
        tick();
        vram_req = 1'b0;
        tick();
        cpu_stop();
        drain("collision");
        chk("cpu_after_vid_ack", last_gap, 1);

        // Randomized traffic
        for (int i = 0; i < 150; i++) begin
            op   = int'($urandom_range(0, 3));
            va   = 15'($urandom);
            ca   = 23'($urandom_range(0, 16'hFFFF));
            d    = 8'($urandom);
            hold = int'($urandom_range(1, 6));
            case (op)
                0: begin
                    exp_vid(va);
                    vid_strobe(va);
                end
                1, 2: begin
                    exp_cpu(ca, op == 2, d);
                    cpu_start(ca, op == 2, d);
                    repeat (hold) tick();
                    cpu_stop();
                end
                default: begin
                    exp_vid(va);
                    exp_cpu(ca, d[0], d);
                    vram_addr = va;
                    vram_req  = 1'b1;
                    cpu_start(ca, d[0], d);
                    tick();
                    vram_req = 1'b0;
                    repeat (hold - 1) tick();
                    cpu_stop();
                end
            endcase
            drain("rand");
            chk("overrun_clear", 32'(vid_overrun), 0);
            repeat ($urandom_range(0, 3)) tick();
        end

        // Overrun: two strobes while a CPU access is in flight
        force_lat = 6;
        va  = 15'h0100;
        va2 = 15'h0200;
        ca  = 23'h001235;
        exp_cpu(ca, 1'b0, 8'h00);
        cpu_start(ca, 1'b0, 8'h00);
        repeat (3) tick();
        vid_strobe(va);
        tick();
        exp_vid(va2);
        vid_strobe(va2);
        cpu_stop();
        drain("overrun");
        chk("overrun_set", 32'(vid_overrun), 1);
        force_lat = 0;
        exp_vid(15'h0042);
        vid_strobe(15'h0042);
        drain("overrun_sticky");
        chk("overrun_sticky", 32'(vid_overrun), 1);

        // Reset between sd_req and sd_ack of a video fetch
        force_lat = 4;
        skip_stab = 1'b1;
        n0 = n_req;
        begin
            sd_cmd_t e;
            e.addr = 22'h000777;
            e.we   = 1'b0;
            e.be   = 2'b11;
            e.dout = '0;
            sd_q.push_back(e);
        end
        vid_strobe(15'h0777);
        t = 0;
        while (n_req == n0 && t < 20) begin
            tick();
            t++;
        end
        chk("rst_mid_req_seen", 32'(t >= 20), 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_mem_din = 8'hFF;
        chk("rstmid_sd_req", 32'(sd_req), 0);
        chk("rstmid_sd_addr", 32'(sd_addr), 0);
        chk("rstmid_sd_be", 32'(sd_be), 0);
        chk("rstmid_vram_din", 32'(vram_din), 32'hFFFF);
        chk("rstmid_mem_din", 32'(mem_din), 32'hFF);
        chk("rstmid_overrun", 32'(vid_overrun), 0);
        n0 = n_vvalid;
        drain("rst_mid");
        repeat (3) tick();
        chk("rstmid_no_valid", n_vvalid - n0, 0);
        chk("rstmid_vram_din_kept", 32'(vram_din), 32'hFFFF);
        skip_stab = 1'b0;
        force_lat = 0;

        // Recovery after reset
        exp_vid(15'h1234);
        vid_strobe(15'h1234);
        drain("recover");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
